// File: rtl/ram_burst_pkg.sv
// Shared definitions for the RAM burst initiator: default geometry and
// the legacy-compatible FSM state encodings.
package ram_burst_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 3;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
   localparam logic [STATE_W-1:0] ST_WR     = 3'd1;
   localparam logic [STATE_W-1:0] ST_RD_REQ = 3'd2;
   localparam logic [STATE_W-1:0] ST_RD_CAP = 3'd3;
   localparam logic [STATE_W-1:0] ST_RD_OUT = 3'd4;

endpackage

// File: rtl/ram_burst_master_if.sv
// Bundle of the command, write-stream, read-stream, status and RAM-side
// signals of the burst initiator. "master" is the initiator's view,
// "slave" is the view of the client plus the RAM attached to it.
interface ram_burst_master_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   // command port
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_wr;
   logic [ADDR_W-1:0] cmd_addr;
   logic [ADDR_W-1:0] cmd_len;
   // write-data stream
   logic              wdata_valid;
   logic [DATA_W-1:0] wdata;
   logic              wdata_ready;
   // read-data stream
   logic              rdata_valid;
   logic [DATA_W-1:0] rdata;
   logic              rdata_ready;
   // status
   logic              busy;
   logic              done;
   // single-port RAM
   logic              ram_en;
   logic              ram_wr;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
      input  wdata_valid, wdata,
      input  rdata_ready,
      input  ram_rdata,
      output cmd_ready, wdata_ready,
      output rdata_valid, rdata,
      output busy, done,
      output ram_en, ram_wr, ram_addr, ram_wdata
   );

   modport slave (
      output cmd_valid, cmd_wr, cmd_addr, cmd_len,
      output wdata_valid, wdata,
      output rdata_ready,
      output ram_rdata,
      input  cmd_ready, wdata_ready,
      input  rdata_valid, rdata,
      input  busy, done,
      input  ram_en, ram_wr, ram_addr, ram_wdata
   );

endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port RAM with registered read data.
// Write bursts stream one beat per cycle straight onto the RAM port;
// read bursts take three cycles per beat (strobe, capture, present) so
// a stalled sink never loses data and the RAM is never accessed twice
// for the same beat.
module ram_burst_master
   import ram_burst_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic               clk,
   input  logic               rstn,
   ram_burst_master_if.master bus
);

   logic [STATE_W-1:0] state_q,       state_d;
   logic [ADDR_W-1:0]  addr_q,        addr_d;
   logic [ADDR_W-1:0]  remain_q,      remain_d;
   logic [DATA_W-1:0]  rdata_q,       rdata_d;
   logic               rdata_valid_q, rdata_valid_d;
   logic               done_q,        done_d;

   logic               last_beat;

   assign last_beat = (remain_q == '0);

   // Next-state logic: command capture, beat accounting and read capture.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
      state_d       = state_q;
      addr_d        = addr_q;
      remain_d      = remain_q;
      rdata_d       = rdata_q;
      rdata_valid_d = rdata_valid_q;
      done_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               addr_d   = bus.cmd_addr;
               remain_d = bus.cmd_len;
               state_d  = bus.cmd_wr ? ST_WR : ST_RD_REQ;
            end
         end

         ST_WR: begin
            // a missing beat simply stalls the burst
            if (bus.wdata_valid) begin
               addr_d = addr_q + ADDR_W'(1);
               if (last_beat) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  remain_d = remain_q - ADDR_W'(1);
               end
            end
         end

         ST_RD_REQ: begin
            state_d = ST_RD_CAP;
         end

         ST_RD_CAP: begin
            // RAM output is valid the cycle after the strobe
            rdata_d       = bus.ram_rdata;
            rdata_valid_d = 1'b1;
            state_d       = ST_RD_OUT;
         end

         ST_RD_OUT: begin
            // beat is held until the sink takes it
            if (bus.rdata_ready) begin
               rdata_valid_d = 1'b0;
               addr_d        = addr_q + ADDR_W'(1);
               if (last_beat) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  remain_d = remain_q - ADDR_W'(1);
                  state_d  = ST_RD_REQ;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any burst in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         remain_q      <= '0;
         rdata_q       <= '0;
         rdata_valid_q <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
         state_q       <= state_d;
         addr_q        <= addr_d;
         remain_q      <= remain_d;
         rdata_q       <= rdata_d;
         rdata_valid_q <= rdata_valid_d;
         done_q        <= done_d;
      end
   end

   // RAM port and handshake outputs decoded from the current state, so
   // they drop the instant reset asserts.
   always_comb begin
      bus.cmd_ready   = 1'b0;
      bus.wdata_ready = 1'b0;
      bus.ram_en      = 1'b0;
      bus.ram_wr      = 1'b0;
      bus.ram_addr    = '0;
      bus.ram_wdata   = '0;

      case (state_q)
         ST_IDLE: begin
            bus.cmd_ready = 1'b1;
         end
         ST_WR: begin
            bus.wdata_ready = 1'b1;
            bus.ram_en      = bus.wdata_valid;
            bus.ram_wr      = 1'b1;
            bus.ram_addr    = addr_q;
            bus.ram_wdata   = bus.wdata;
         end
         ST_RD_REQ: begin
            bus.ram_en   = 1'b1;
            bus.ram_addr = addr_q;
         end
         default: begin
         end
      endcase
   end

   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = done_q;
   assign bus.rdata       = rdata_q;
   assign bus.rdata_valid = rdata_valid_q;

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench for ram_burst_master: a cycle-by-cycle vector table
// for the plain write/read/gapped-write flow, then directed sequences for
// wrap-around, read backpressure and reset in the middle of a burst.
module tb_ram_burst_master;
   import ram_burst_pkg::*;

   logic clk;
   logic rstn;

   ram_burst_master_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   ram_burst_master #(.DATA_W(8), .ADDR_W(3)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM: registered read, output held when idle,
   // output cleared by reset.
   logic [7:0] mem [8];
   logic [7:0] ram_q;

   always @(posedge clk) begin
      if (bus.ram_en && bus.ram_wr) mem[bus.ram_addr] <= bus.ram_wdata;
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn)                        ram_q <= 8'h00;
      else if (bus.ram_en && !bus.ram_wr) ram_q <= mem[bus.ram_addr];
   end

   assign bus.ram_rdata = ram_q;

   // Event counters sampled on the active edge.
   int strobes = 0;
   int dones   = 0;
   always @(posedge clk) begin
      if (rstn && bus.ram_en) strobes++;
      if (rstn && bus.done)   dones++;
   end

   // Expected RAM contents, maintained by the bench from what it wrote.
   logic [7:0] shadow [8];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       cv;
      logic       cw;
      logic [2:0] ca;
      logic [2:0] cl;
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       e_cr;
      logic       e_wrdy;
      logic       e_en;
      logic       e_we;
      logic [2:0] e_addr;
      logic [7:0] e_wd;
      logic       e_rv;
      logic [7:0] e_rd;
      logic       e_done;
   } vec_t;

   function automatic vec_t mk(
      input logic cv, input logic cw, input logic [2:0] ca, input logic [2:0] cl,
      input logic wv, input logic [7:0] wd, input logic rr,
      input logic e_cr, input logic e_wrdy, input logic e_en, input logic e_we,
      input logic [2:0] e_addr, input logic [7:0] e_wd,
      input logic e_rv, input logic [7:0] e_rd, input logic e_done);
      vec_t v;
      v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl;
      v.wv = wv; v.wd = wd; v.rr = rr;
      v.e_cr = e_cr; v.e_wrdy = e_wrdy; v.e_en = e_en; v.e_we = e_we;
      v.e_addr = e_addr; v.e_wd = e_wd;
      v.e_rv = e_rv; v.e_rd = e_rd; v.e_done = e_done;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write burst with wdata_valid held high; data = base + beat.
   task automatic write_burst(input logic [2:0] addr, input logic [2:0] len,
                              input logic [7:0] base, input string tag);
      int s0;
      logic [2:0] a;
      s0 = strobes;
      bus.cmd_valid = 1'b1;
      bus.cmd_wr    = 1'b1;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      tick();
      bus.cmd_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         a = addr + 3'(b);
         bus.wdata_valid = 1'b1;
         bus.wdata       = base + 8'(b);
         @(negedge clk);
         check({tag, ".wrdy"}, 32'(bus.wdata_ready), 32'd1);
         check({tag, ".addr"}, 32'(bus.ram_addr), 32'(a));
         tick();
         shadow[a] = base + 8'(b);
      end
      bus.wdata_valid = 1'b0;
      bus.wdata       = 8'h00;
      @(negedge clk);
      check({tag, ".done"}, 32'(bus.done), 32'd1);
      check({tag, ".strobes"}, 32'(strobes - s0), 32'(int'(len) + 1));
      tick();
   endtask

   // Read burst checked against the shadow; optional stall on one beat.
   task automatic read_burst(input logic [2:0] addr, input logic [2:0] len,
                             input int stall_beat, input int stall_n, input string tag);
      int s0, d0, lat;
      logic [2:0] a;
      logic [7:0] held;
      s0 = strobes;
      d0 = dones;
      bus.rdata_ready = 1'b1;
      bus.cmd_valid   = 1'b1;
      bus.cmd_wr      = 1'b0;
      bus.cmd_addr    = addr;
      bus.cmd_len     = len;
      tick();
      bus.cmd_valid = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         a = addr + 3'(b);
         if (b == stall_beat) bus.rdata_ready = 1'b0;
         lat = 1;
         @(negedge clk);
         while (!bus.rdata_valid && lat < 10) begin
            tick();
            @(negedge clk);
            lat++;
         end
         check({tag, ".latency"}, 32'(lat), 32'd3);
         if (!bus.rdata_valid) begin
            bus.rdata_ready = 1'b1;
            tick();
            return;
         end
         if (b == stall_beat) begin
            held = bus.rdata;
            for (int s = 1; s < stall_n; s++) begin
               tick();
               @(negedge clk);
               check({tag, ".stall_valid"}, 32'(bus.rdata_valid), 32'd1);
               check({tag, ".stall_data"}, 32'(bus.rdata), 32'(held));
            end
            tick();
            bus.rdata_ready = 1'b1;
            @(negedge clk);
         end
         check({tag, ".data"}, 32'(bus.rdata), 32'(shadow[a]));
         tick();
      end
      @(negedge clk);
      check({tag, ".done"}, 32'(bus.done), 32'd1);
      check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      check({tag, ".strobes"}, 32'(strobes - s0), 32'(int'(len) + 1));
      tick();
      @(negedge clk);
      check({tag, ".done_pulse"}, 32'(bus.done), 32'd0);
      check({tag, ".done_count"}, 32'(dones - d0), 32'd1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t vecs[$];
      int s0, d0, seen;
      logic [7:0] wpat [5];
      logic       vpat [5];
      logic [2:0] apat [5];

      // ---- stimulus table: write 8, back-to-back read 8, gapped write 3 ----
      vecs.push_back(mk(1, 1, 3'd0, 3'd7, 0, 8'h00, 1,  1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 0));
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(0, 0, 3'd0, 3'd0, 1, 8'(8'h10 + i), 1,
                           0, 1, 1, 1, 3'(i), 8'(8'h10 + i), 0, 8'h00, 0));
      vecs.push_back(mk(1, 0, 3'd0, 3'd7, 0, 8'h00, 1,  1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 1));
      for (int k = 0; k < 8; k++) begin
         vecs.push_back(mk(0, 0, 3'd0, 3'd0, 0, 8'h00, 1,  0, 0, 1, 0, 3'(k), 8'h00, 0, 8'h00, 0));
         vecs.push_back(mk(0, 0, 3'd0, 3'd0, 0, 8'h00, 1,  0, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 0));
         vecs.push_back(mk(0, 0, 3'd0, 3'd0, 0, 8'h00, 1,  0, 0, 0, 0, 3'd0, 8'h00, 1, 8'(8'h10 + k), 0));
      end
      vecs.push_back(mk(1, 1, 3'd3, 3'd2, 0, 8'h00, 1,  1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 1));
      vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      wpat = '{8'hB0, 8'h00, 8'h00, 8'hB1, 8'hB2};
      apat = '{3'd3, 3'd4, 3'd4, 3'd4, 3'd5};
      for (int g = 0; g < 5; g++)
         vecs.push_back(mk(0, 0, 3'd0, 3'd0, vpat[g], wpat[g], 1,
                           0, 1, vpat[g], 1, apat[g], wpat[g], 0, 8'h00, 0));
      vecs.push_back(mk(0, 0, 3'd0, 3'd0, 0, 8'h00, 1,  1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 1));
      vecs.push_back(mk(0, 0, 3'd0, 3'd0, 0, 8'h00, 1,  1, 0, 0, 0, 3'd0, 8'h00, 0, 8'h00, 0));

      // ---- reset ----
      rstn            = 1'b0;
      bus.cmd_valid   = 1'b0;
      bus.cmd_wr      = 1'b0;
      bus.cmd_addr    = 3'd0;
      bus.cmd_len     = 3'd0;
      bus.wdata_valid = 1'b0;
      bus.wdata       = 8'h00;
      bus.rdata_ready = 1'b0;
      #3;
      check("reset.cmd_ready",   32'(bus.cmd_ready),   32'd1);
      check("reset.busy",        32'(bus.busy),        32'd0);
      check("reset.ram_en",      32'(bus.ram_en),      32'd0);
      check("reset.rdata_valid", 32'(bus.rdata_valid), 32'd0);
      check("reset.rdata",       32'(bus.rdata),       32'd0);
      check("reset.done",        32'(bus.done),        32'd0);
      tick();
      tick();
      rstn = 1'b1;
      tick();

      // ---- table-driven phase ----
      s0 = strobes;
      d0 = dones;
      for (int i = 0; i < vecs.size(); i++) begin
         bus.cmd_valid   = vecs[i].cv;
         bus.cmd_wr      = vecs[i].cw;
         bus.cmd_addr    = vecs[i].ca;
         bus.cmd_len     = vecs[i].cl;
         bus.wdata_valid = vecs[i].wv;
         bus.wdata       = vecs[i].wd;
         bus.rdata_ready = vecs[i].rr;
         @(negedge clk);
         check($sformatf("v%0d.cmd_ready", i),   32'(bus.cmd_ready),   32'(vecs[i].e_cr));
         check($sformatf("v%0d.busy", i),        32'(bus.busy),        32'(!vecs[i].e_cr));
         check($sformatf("v%0d.wdata_ready", i), 32'(bus.wdata_ready), 32'(vecs[i].e_wrdy));
         check($sformatf("v%0d.ram_en", i),      32'(bus.ram_en),      32'(vecs[i].e_en));
         check($sformatf("v%0d.ram_wr", i),      32'(bus.ram_wr),      32'(vecs[i].e_we));
         check($sformatf("v%0d.ram_addr", i),    32'(bus.ram_addr),    32'(vecs[i].e_addr));
         check($sformatf("v%0d.ram_wdata", i),   32'(bus.ram_wdata),   32'(vecs[i].e_wd));
         check($sformatf("v%0d.rdata_valid", i), 32'(bus.rdata_valid), 32'(vecs[i].e_rv));
         if (vecs[i].e_rv)
            check($sformatf("v%0d.rdata", i),    32'(bus.rdata),       32'(vecs[i].e_rd));
         check($sformatf("v%0d.done", i),        32'(bus.done),        32'(vecs[i].e_done));
         tick();
      end
      bus.cmd_valid   = 1'b0;
      bus.wdata_valid = 1'b0;
      bus.wdata       = 8'h00;
      check("table.strobes", 32'(strobes - s0), 32'd19);
      check("table.dones",   32'(dones - d0),   32'd3);
      for (int i = 0; i < 8; i++) shadow[i] = 8'(8'h10 + i);
      shadow[3] = 8'hB0;
      shadow[4] = 8'hB1;
      shadow[5] = 8'hB2;
      check("gap.mem3", 32'(mem[3]), 32'h00B0);
      check("gap.mem5", 32'(mem[5]), 32'h00B2);

      // ---- wrap-around write and read-back ----
      write_burst(3'd6, 3'd3, 8'hA0, "wrap_wr");
      check("wrap.mem6", 32'(mem[6]), 32'h00A0);
      check("wrap.mem7", 32'(mem[7]), 32'h00A1);
      check("wrap.mem0", 32'(mem[0]), 32'h00A2);
      check("wrap.mem1", 32'(mem[1]), 32'h00A3);
      read_burst(3'd6, 3'd3, -1, 0, "wrap_rd");

      // ---- read with the sink stalled for 5 cycles on beat 2 ----
      read_burst(3'd0, 3'd7, 2, 5, "stall_rd");

      // ---- reset in the middle of an 8-beat read ----
      d0 = dones;
      seen = 0;
      bus.rdata_ready = 1'b1;
      bus.cmd_valid   = 1'b1;
      bus.cmd_wr      = 1'b0;
      bus.cmd_addr    = 3'd0;
      bus.cmd_len     = 3'd7;
      tick();
      bus.cmd_valid = 1'b0;
      for (int t = 0; t < 40 && seen < 3; t++) begin
         @(negedge clk);
         if (bus.ram_en) seen++;
         if (seen < 3) tick();
      end
      check("rst.reached_beat3", 32'(seen), 32'd3);
      #1;
      rstn = 1'b0;
      #1;
      check("rst.ram_en",      32'(bus.ram_en),      32'd0);
      check("rst.rdata_valid", 32'(bus.rdata_valid), 32'd0);
      check("rst.rdata",       32'(bus.rdata),       32'd0);
      check("rst.busy",        32'(bus.busy),        32'd0);
      check("rst.done",        32'(bus.done),        32'd0);
      for (int t = 0; t < 2; t++) begin
         tick();
         check("rst.hold_done",   32'(bus.done),   32'd0);
         check("rst.hold_ram_en", 32'(bus.ram_en), 32'd0);
      end
      rstn = 1'b1;
      tick();
      check("rst.no_done", 32'(dones - d0), 32'd0);
      write_burst(3'd2, 3'd0, 8'h5C, "post_wr");
      read_burst(3'd2, 3'd0, -1, 0, "post_rd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
